// File: rtl/inst_buffer_pkg.sv
// Shared types and helpers for the instruction buffer.
// Provides:
//   - XLEN, INST_W  : PC and instruction widths
//   - IB_WIDTH      : default superscalar width (fetch/decode/dispatch lanes)
//   - IB_DEPTH      : default buffer depth (power of 2, >= 2*IB_WIDTH)
//   - ib_entry_t    : one stored instruction with its PC
//   - valid_prefix_len() : length of the contiguous valid run starting at lane 0
package inst_buffer_pkg;

   localparam int XLEN      = 32;
   localparam int INST_W    = 32;
   localparam int IB_WIDTH  = 3;
   localparam int IB_DEPTH  = 16;
   localparam int MAX_LANES = 8;

   typedef logic [INST_W-1:0] inst_t;

   typedef struct packed {
      inst_t            inst;
      logic [XLEN-1:0]  pc;
   } ib_entry_t;

   // Lanes after the first invalid one are dropped, so 3'b101 counts as 1.
   function automatic int unsigned valid_prefix_len(input logic [MAX_LANES-1:0] valid,
                                                    input int unsigned lanes);
      int unsigned n;
      logic        run;
      n   = 0;
      run = 1'b1;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         if (i < lanes && run) begin
            if (valid[i]) n = n + 1;
            else          run = 1'b0;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode/dispatch bundle of the instruction buffer.
// Signals:
//   flush        squash all buffer contents
//   fetch_inst   fetched instructions, lane 0 oldest
//   fetch_pc     PC of each fetch lane
//   fetch_valid  per-lane valid from fetch
//   fetch_ready  buffer will accept a full WIDTH group
//   dec_inst     oldest entries presented to the decoders
//   dec_pc       PCs of the dec_inst lanes
//   dec_valid    per-lane decoder valid
//   dispatch_num entries consumed this cycle
//   count        current occupancy
// Modports: master = pipeline side, slave = the buffer.
interface inst_buffer_if
   import inst_buffer_pkg::*;
#(
   parameter int WIDTH = IB_WIDTH,
   parameter int DEPTH = IB_DEPTH
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = $clog2(WIDTH + 1);

   logic                              flush;
   logic [WIDTH-1:0][INST_W-1:0]      fetch_inst;
   logic [WIDTH-1:0][XLEN-1:0]        fetch_pc;
   logic [WIDTH-1:0]                  fetch_valid;
   logic                              fetch_ready;
   logic [WIDTH-1:0][INST_W-1:0]      dec_inst;
   logic [WIDTH-1:0][XLEN-1:0]        dec_pc;
   logic [WIDTH-1:0]                  dec_valid;
   logic [DW-1:0]                     dispatch_num;
   logic [CW-1:0]                     count;

   modport master (
      output flush, fetch_inst, fetch_pc, fetch_valid, dispatch_num,
      input  fetch_ready, dec_inst, dec_pc, dec_valid, count
   );

   modport slave (
      input  flush, fetch_inst, fetch_pc, fetch_valid, dispatch_num,
      output fetch_ready, dec_inst, dec_pc, dec_valid, count
   );

endinterface

// File: rtl/inst_buffer.sv
// In-order circular instruction buffer between fetch and WIDTH parallel decoders.
// Accepts up to WIDTH instructions per cycle, presents the oldest WIDTH entries
// (oldest in lane 0) and retires dispatch_num entries per cycle.
// Ports:
//   clock    sole clock, all state on posedge
//   reset_n  synchronous active-low reset (priority over flush)
//   ib       inst_buffer_if.slave bundle (fetch, decode, dispatch, count)
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int WIDTH = IB_WIDTH,
   parameter int DEPTH = IB_DEPTH
)(
   input  logic           clock,
   input  logic           reset_n,
   inst_buffer_if.slave   ib
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = $clog2(WIDTH + 1);

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   ib_entry_t       mem_q [DEPTH];

   logic            ready;
   logic [DW-1:0]   n_enq;
   logic [DW-1:0]   n_avail;

   // Credit comes only from the registered count; a same-cycle dequeue does
   // not make room, so a whole group is guaranteed to fit.
   always_comb begin
      ready = (count_q <= CW'(DEPTH - WIDTH)) && !ib.flush;
      n_enq = '0;
      if (ready) n_enq = DW'(valid_prefix_len(MAX_LANES'(ib.fetch_valid), WIDTH));
   end

   assign ib.fetch_ready = ready;
   assign ib.count       = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (ib.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(ib.dispatch_num);
         tail_d  = tail_q + PW'(n_enq);
         count_d = count_q + CW'(n_enq) - CW'(ib.dispatch_num);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; pointer arithmetic wraps naturally at PW bits.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (DW'(i) < n_enq) begin
               mem_q[tail_q + PW'(i)] <= '{inst: ib.fetch_inst[i], pc: ib.fetch_pc[i]};
            end
         end
      end
   end

   // Read side is purely from registered storage: no fetch-to-decode bypass.
   always_comb begin
      ib.dec_inst  = '0;
      ib.dec_pc    = '0;
      ib.dec_valid = '0;
      n_avail      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ib.dec_inst[i]  = mem_q[head_q + PW'(i)].inst;
         ib.dec_pc[i]    = mem_q[head_q + PW'(i)].pc;
         ib.dec_valid[i] = (count_q > CW'(i)) && !ib.flush;
         if (ib.dec_valid[i]) n_avail = n_avail + DW'(1);
      end
   end

   a_dispatch_legal: assert property (
      @(posedge clock) disable iff (!reset_n || ib.flush)
      ib.dispatch_num <= n_avail
   ) else $error("dispatch_num exceeds valid decoder lanes");

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer contents.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int W = 3;
   localparam int D = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   inst_buffer_if #(.WIDTH(W), .DEPTH(D)) ib ();

   inst_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .ib      (ib.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        model_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pc_next  = 32'h0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int   sz;
      logic exp_v;
      sz = model_q.size();
      chk("count", 64'(ib.count), 64'(sz));
      chk("fetch_ready", 64'(ib.fetch_ready), 64'((sz <= D - W) && !ib.flush));
      for (int i = 0; i < W; i++) begin
         exp_v = (i < sz) && !ib.flush;
         chk("dec_valid", 64'(ib.dec_valid[i]), 64'(exp_v));
         if (i < sz) begin
            chk("dec_pc", 64'(ib.dec_pc[i]), 64'(model_q[i].pc));
            chk("dec_inst", 64'(ib.dec_inst[i]), 64'(model_q[i].inst));
         end
      end
   endtask

   // One clock: drive inputs, check outputs before the edge, update the model.
   task automatic cycle(input logic rn, input logic fl, input logic [W-1:0] fv, input int dn);
      int   n;
      logic run;
      reset_n         = rn;
      ib.flush        = fl;
      ib.fetch_valid  = fv;
      ib.dispatch_num = dn[1:0];
      for (int i = 0; i < W; i++) begin
         ib.fetch_pc[i]   = pc_next + 32'(4 * i);
         ib.fetch_inst[i] = $urandom;
      end
      #2;
      check_outputs();
      n   = 0;
      run = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (run && fv[i]) n++;
         else              run = 1'b0;
      end
      if (model_q.size() > D - W || fl) n = 0;
      @(posedge clock);
      if (!rn || fl) begin
         model_q.delete();
      end else begin
         repeat (dn) void'(model_q.pop_front());
         for (int i = 0; i < n; i++) model_q.push_back('{ib.fetch_inst[i], ib.fetch_pc[i]});
         pc_next = pc_next + 32'(4 * n);
      end
      #1;
   endtask

   task automatic idle();
      reset_n         = 1'b1;
      ib.flush        = 1'b0;
      ib.fetch_valid  = '0;
      ib.dispatch_num = '0;
      #1;
   endtask

   initial begin
      logic [31:0] p;
      int          dn_max;
      logic        rn, fl;

      ib.flush        = 1'b0;
      ib.fetch_valid  = '0;
      ib.dispatch_num = '0;
      ib.fetch_pc     = '0;
      ib.fetch_inst   = '0;
      reset_n         = 1'b0;
      @(posedge clock);
      #1;
      idle();
      chk("reset_count", 64'(ib.count), 64'd0);
      chk("reset_dec_valid", 64'(ib.dec_valid), 64'd0);
      chk("reset_fetch_ready", 64'(ib.fetch_ready), 64'd1);

      // First group becomes visible one cycle later.
      cycle(1, 0, 3'b111, 0);
      idle();
      chk("t1_dec_valid", 64'(ib.dec_valid), 64'b111);
      chk("t1_pc0", 64'(ib.dec_pc[0]), 64'd0);
      chk("t1_pc1", 64'(ib.dec_pc[1]), 64'd4);
      chk("t1_pc2", 64'(ib.dec_pc[2]), 64'd8);
      chk("t1_count", 64'(ib.count), 64'd3);

      // Fill until fetch_ready drops, then a dequeue restores credit.
      repeat (5) cycle(1, 0, 3'b111, 0);
      idle();
      chk("t2_count_full", 64'(ib.count), 64'd15);
      chk("t2_ready_full", 64'(ib.fetch_ready), 64'd0);
      cycle(1, 0, 3'b111, 2);
      idle();
      chk("t2_count_after", 64'(ib.count), 64'd13);
      chk("t2_ready_after", 64'(ib.fetch_ready), 64'd1);

      // Drain to 3, then steady 3-in/3-out across several pointer wraps.
      repeat (4) cycle(1, 0, 3'b000, 3);
      cycle(1, 0, 3'b111, 1);
      repeat (20) cycle(1, 0, 3'b111, 3);
      idle();
      chk("t3_count", 64'(ib.count), 64'd3);

      // Partial valid patterns.
      cycle(1, 0, 3'b000, 3);
      p = pc_next;
      cycle(1, 0, 3'b101, 0);
      idle();
      chk("t4_count_101", 64'(ib.count), 64'd1);
      chk("t4_valid_101", 64'(ib.dec_valid), 64'b001);
      chk("t4_pc_101", 64'(ib.dec_pc[0]), 64'(p));
      cycle(1, 0, 3'b000, 1);
      cycle(1, 0, 3'b110, 0);
      idle();
      chk("t4_count_011", 64'(ib.count), 64'd0);

      // Flush with simultaneous enqueue and dequeue.
      repeat (3) cycle(1, 0, 3'b111, 0);
      cycle(1, 0, 3'b000, 2);
      idle();
      chk("t5_count_pre", 64'(ib.count), 64'd7);
      ib.flush        = 1'b1;
      ib.fetch_valid  = 3'b111;
      ib.dispatch_num = 2'd3;
      #1;
      chk("t5_flush_dec_valid", 64'(ib.dec_valid), 64'd0);
      chk("t5_flush_ready", 64'(ib.fetch_ready), 64'd0);
      cycle(1, 1, 3'b111, 3);
      idle();
      chk("t5_count_post", 64'(ib.count), 64'd0);
      chk("t5_dec_valid_post", 64'(ib.dec_valid), 64'd0);
      chk("t5_ready_post", 64'(ib.fetch_ready), 64'd1);

      // Reset while busy, then a fresh group.
      repeat (3) cycle(1, 0, 3'b111, 0);
      cycle(0, 0, 3'b111, 2);
      idle();
      chk("t6_count", 64'(ib.count), 64'd0);
      chk("t6_dec_valid", 64'(ib.dec_valid), 64'd0);
      p = pc_next;
      cycle(1, 0, 3'b111, 0);
      idle();
      chk("t6_fresh_pc0", 64'(ib.dec_pc[0]), 64'(p));
      chk("t6_fresh_pc2", 64'(ib.dec_pc[2]), 64'(p + 32'd8));
      chk("t6_fresh_count", 64'(ib.count), 64'd3);

      // Random traffic with legal dispatch counts.
      for (int k = 0; k < 400; k++) begin
         dn_max = (model_q.size() < W) ? model_q.size() : W;
         rn     = ($urandom_range(49, 0) != 0);
         fl     = ($urandom_range(19, 0) == 0);
         cycle(rn, fl, 3'($urandom_range(7, 0)), int'($urandom_range(dn_max, 0)));
      end
      idle();
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
